// File: rtl/con_ff_unit.sv
// CON FF branch-condition unit: captures operand and condition on ConIn, resolves the branch
// decision one cycle later and holds it until acknowledged. Define CON_FF_STATS_EN for counters.
module con_ff_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IR_WIDTH   = 32,
    parameter int unsigned COND_LSB   = 19,
    parameter int unsigned COND_BITS  = 3,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  ConIn,
    input  logic [DATA_WIDTH-1:0] BusMuxIn,
    input  logic [IR_WIDTH-1:0]   IR,
    input  logic                  branch_ack,
    output logic                  branch,
    output logic                  branch_valid,
    output logic                  busy
`ifdef CON_FF_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] taken_count,
    output logic [STAT_WIDTH-1:0] eval_count
`endif
);

    if (!(COND_BITS == 2 || COND_BITS == 3)) begin : gen_bad_cond_bits
        $error("con_ff_unit: COND_BITS must be 2 or 3");
    end
    if (STAT_WIDTH == 0 || COND_LSB + COND_BITS > IR_WIDTH || DATA_WIDTH == 0) begin : gen_bad_widths
        $error("con_ff_unit: illegal width parameters");
    end

    typedef enum logic [1:0] {Idle, Eval, Hold} state_e;

    state_e                state;
    logic [DATA_WIDTH-1:0] opReg;
    logic [COND_BITS-1:0]  condReg;
    logic [2:0]            condExt;
    logic                  isZero;
    logic                  isNeg;
    logic                  decision;

    // Only the condition field of IR matters; reduce the rest so it is visibly consumed.
    logic unusedIr;
    assign unusedIr = ^IR;

    always_comb begin
        condExt  = 3'(condReg);
        isZero   = ~|opReg;
        isNeg    = opReg[DATA_WIDTH-1];
        decision = 1'b0;
        case (condExt)
            3'b000:  decision = isZero;
            3'b001:  decision = !isZero;
            3'b010:  decision = !isNeg;
            3'b011:  decision = isNeg;
            3'b100:  decision = !isNeg && !isZero;
            3'b101:  decision = isNeg || isZero;
            3'b110:  decision = 1'b1;
            default: decision = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state        <= Idle;
            opReg        <= '0;
            condReg      <= '0;
            branch       <= 1'b0;
            branch_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef CON_FF_STATS_EN
            taken_count  <= '0;
            eval_count   <= '0;
`endif
        end else begin
            case (state)
                Idle: begin
                    if (ConIn) begin
                        opReg   <= BusMuxIn;
                        condReg <= IR[COND_LSB +: COND_BITS];
                        state   <= Eval;
                        busy    <= 1'b1;
                    end
                end
                Eval: begin
                    branch       <= decision;
                    branch_valid <= 1'b1;
                    state        <= Hold;
`ifdef CON_FF_STATS_EN
                    eval_count   <= eval_count + 1'b1;
                    if (decision) taken_count <= taken_count + 1'b1;
`endif
                end
                Hold: begin
                    // ConIn arriving with the ack is dropped, not queued.
                    if (branch_ack) begin
                        branch_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= Idle;
                    end
                end
                default: begin
                    branch_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= Idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_con_ff_unit.sv
// Directed self-checking bench for con_ff_unit (default build, statistics disabled).
module tb_con_ff_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic        ConIn;
    logic [31:0] BusMuxIn;
    logic [31:0] IR;
    logic        branch_ack;
    logic        branch;
    logic        branch_valid;
    logic        busy;

    int nChecks = 0;
    int nPass   = 0;

    con_ff_unit dut (
        .clock        (clock),
        .clear        (clear),
        .ConIn        (ConIn),
        .BusMuxIn     (BusMuxIn),
        .IR           (IR),
        .branch_ack   (branch_ack),
        .branch       (branch),
        .branch_valid (branch_valid),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Condition field placed in an IR whose other bits are all ones.
    function automatic logic [31:0] mkIr(input logic [2:0] cond);
        logic [31:0] v;
        v = 32'hFFFF_FFFF;
        v[21:19] = cond;
        return v;
    endfunction

    task automatic doEval(input string tag, input logic [31:0] op, input logic [2:0] cond,
                          input logic expBranch);
        BusMuxIn = op;
        IR       = mkIr(cond);
        ConIn    = 1'b1;
        tick();
        ConIn    = 1'b0;
        tick();
        check({tag, ".branch"}, {31'b0, branch}, {31'b0, expBranch});
        check({tag, ".valid"}, {31'b0, branch_valid}, 32'd1);
        branch_ack = 1'b1;
        tick();
        branch_ack = 1'b0;
        check({tag, ".ackValid"}, {31'b0, branch_valid}, 32'd0);
    endtask

    initial begin
        clear      = 1'b1;
        ConIn      = 1'b0;
        BusMuxIn   = '0;
        IR         = '0;
        branch_ack = 1'b0;

        // Reset holds the unit idle even with ConIn toggling.
        for (int i = 0; i < 4; i++) begin
            ConIn = ~ConIn;
            tick();
        end
        check("rst.branch", {31'b0, branch}, 32'd0);
        check("rst.valid", {31'b0, branch_valid}, 32'd0);
        check("rst.busy", {31'b0, busy}, 32'd0);
        ConIn = 1'b0;
        clear = 1'b0;
        tick();
        check("rst.idleBusy", {31'b0, busy}, 32'd0);

        // Zero test: one-cycle latency and sticky branch after ack.
        BusMuxIn = 32'h0;
        IR       = mkIr(3'b000);
        ConIn    = 1'b1;
        tick();
        ConIn    = 1'b0;
        check("lat.busyEval", {31'b0, busy}, 32'd1);
        check("lat.validEval", {31'b0, branch_valid}, 32'd0);
        tick();
        check("lat.branch", {31'b0, branch}, 32'd1);
        check("lat.valid", {31'b0, branch_valid}, 32'd1);
        tick();
        check("lat.holdValid", {31'b0, branch_valid}, 32'd1);
        branch_ack = 1'b1;
        tick();
        branch_ack = 1'b0;
        check("lat.ackValid", {31'b0, branch_valid}, 32'd0);
        check("lat.sticky", {31'b0, branch}, 32'd1);
        check("lat.ackBusy", {31'b0, busy}, 32'd0);

        // Condition table, including signed edge cases.
        doEval("c011neg", 32'h8000_0000, 3'b011, 1'b1);
        doEval("c010neg", 32'h8000_0000, 3'b010, 1'b0);
        doEval("c101neg", 32'h8000_0000, 3'b101, 1'b1);
        doEval("c100neg", 32'h8000_0000, 3'b100, 1'b0);
        doEval("c100pos", 32'h0000_0005, 3'b100, 1'b1);
        doEval("c000neg", 32'h8000_0000, 3'b000, 1'b0);
        doEval("c001neg", 32'h8000_0000, 3'b001, 1'b1);
        doEval("c001zero", 32'h0000_0000, 3'b001, 1'b0);
        doEval("c101zero", 32'h0000_0000, 3'b101, 1'b1);
        doEval("c100zero", 32'h0000_0000, 3'b100, 1'b0);
        doEval("c010zero", 32'h0000_0000, 3'b010, 1'b1);
        doEval("c110", 32'h1234_5678, 3'b110, 1'b1);
        doEval("c111", 32'h0000_0000, 3'b111, 1'b0);
        doEval("c000msb0", 32'h0000_0001, 3'b000, 1'b0);

        // ConIn together with ack in HOLD is dropped.
        BusMuxIn = 32'h0;
        IR       = mkIr(3'b000);
        ConIn    = 1'b1;
        tick();
        ConIn    = 1'b0;
        tick();
        check("drop.branch", {31'b0, branch}, 32'd1);
        BusMuxIn   = 32'h5;
        ConIn      = 1'b1;
        tick();
        check("drop.holdIgnore", {31'b0, branch_valid}, 32'd1);
        branch_ack = 1'b1;
        tick();
        ConIn      = 1'b0;
        branch_ack = 1'b0;
        check("drop.valid", {31'b0, branch_valid}, 32'd0);
        check("drop.busy", {31'b0, busy}, 32'd0);
        tick();
        tick();
        check("drop.noEval", {31'b0, branch_valid}, 32'd0);
        check("drop.stillIdle", {31'b0, busy}, 32'd0);
        check("drop.sticky", {31'b0, branch}, 32'd1);

        // Operand change after the capture edge must not affect the decision.
        BusMuxIn = 32'h0;
        IR       = mkIr(3'b001);
        ConIn    = 1'b1;
        tick();
        ConIn    = 1'b0;
        BusMuxIn = 32'h7;
        IR       = mkIr(3'b110);
        tick();
        check("cap.branch", {31'b0, branch}, 32'd0);
        branch_ack = 1'b1;
        tick();
        branch_ack = 1'b0;

        // Asynchronous clear during EVAL.
        doEval("preClr", 32'h0, 3'b110, 1'b1);
        BusMuxIn = 32'h0;
        IR       = mkIr(3'b110);
        ConIn    = 1'b1;
        tick();
        ConIn    = 1'b0;
        check("clr.inEval", {31'b0, busy}, 32'd1);
        #1 clear = 1'b1;
        #1;
        check("clr.branch", {31'b0, branch}, 32'd0);
        check("clr.valid", {31'b0, branch_valid}, 32'd0);
        check("clr.busy", {31'b0, busy}, 32'd0);
        tick();
        clear = 1'b0;
        tick();
        tick();
        check("clr.noDecision", {31'b0, branch_valid}, 32'd0);
        check("clr.idle", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
